// File: rtl/reg_spill_ctrl_pkg.sv
// Shared types and constants for the register spill/fill controller.
// The register file model and the controller both use this package.
package reg_spill_ctrl_pkg;

  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 10;
  localparam int ADDR_W   = 10;
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef logic [IDX_W-1:0]    idx_t;
  typedef logic [NUM_REGS-1:0] mask_t;
  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [ADDR_W-1:0]   addr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAVE,
    ST_RESTORE,
    ST_FINISH
  } state_e;

  function automatic mask_t idx_onehot(input idx_t i);
    return mask_t'(1) << i;
  endfunction

endpackage

// File: rtl/reg_spill_ctrl_if.sv
// Data-memory port of the spill controller; rdata follows re by one cycle.
interface reg_spill_ctrl_if;
  import reg_spill_ctrl_pkg::*;

  addr_t mem_addr;
  data_t mem_wdata;
  logic  mem_we;
  logic  mem_re;
  data_t mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata
  );

endinterface

// File: rtl/reg_spill_ctrl_next_idx_find.sv
// Finds the lowest set mask bit at or above 'from'; 'none' when there is none.
module next_idx_find
  import reg_spill_ctrl_pkg::*;
(
  input  mask_t mask,
  input  idx_t  from,
  output idx_t  idx,
  output logic  none
);

  // NOTE: every combinational output gets a default before the loop, so no latch is inferred.
  always_comb begin
    idx  = '0;
    none = 1'b1;
    // Descending scan so the lowest qualifying index is the one left standing.
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask[i] && (idx_t'(i) >= from)) begin
        idx  = idx_t'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_spill_ctrl.sv
// Copies masked registers to an 8-slot memory area (save) or back (restore).
// Restore writes land one cycle after their read issue, overlapping the next issue.
module reg_spill_ctrl
  import reg_spill_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  start_save,
  input  logic  start_restore,
  input  addr_t base_addr,
  input  mask_t reg_mask,
  output logic  busy,
  output logic  done,
  output idx_t  rd_reg,
  input  data_t rd_data,
  output idx_t  wr_reg,
  output data_t wr_data,
  output logic  wr_en,
  reg_spill_ctrl_if.master mem
);

  if (MEM_LAT != 1) begin : g_lat_check
    $error("reg_spill_ctrl supports MEM_LAT == 1 only");
  end

  state_e state_q, state_d;
  addr_t  base_q, base_d;
  mask_t  mask_q, mask_d;
  idx_t   idx_q, idx_d;
  logic   pend_q, pend_d;
  idx_t   pend_idx_q, pend_idx_d;

  mask_t  srch_mask;
  idx_t   srch_from;
  idx_t   nxt_idx;
  logic   nxt_none;
  logic   issue;
  addr_t  slot_addr;

  // mask_q holds the indices not yet visited, current one included; it empties
  // after the last restore issue, which marks the trailing write cycle.
  assign issue     = (state_q == ST_RESTORE) && (mask_q != '0);
  assign slot_addr = base_q + addr_t'(idx_q);

  always_comb begin
    if (state_q == ST_IDLE) begin
      srch_mask = reg_mask;
      srch_from = '0;
    end else begin
      srch_mask = mask_q & ~idx_onehot(idx_q);
      srch_from = idx_q;
    end
  end

  next_idx_find u_find (
    .mask (srch_mask),
    .from (srch_from),
    .idx  (nxt_idx),
    .none (nxt_none)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      mask_q     <= '0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      mask_q     <= mask_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    mask_d     = mask_q;
    idx_d      = idx_q;
    pend_d     = 1'b0;
    pend_idx_d = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start_save || start_restore) begin
          base_d = base_addr;
          mask_d = reg_mask;
          idx_d  = nxt_idx;
          if (nxt_none)        state_d = ST_FINISH;
          else if (start_save) state_d = ST_SAVE;
          else                 state_d = ST_RESTORE;
        end
      end
      ST_SAVE: begin
        mask_d = srch_mask;
        idx_d  = nxt_idx;
        if (nxt_none) state_d = ST_FINISH;
      end
      ST_RESTORE: begin
        if (issue) begin
          pend_d = 1'b1;
          mask_d = srch_mask;
          idx_d  = nxt_idx;
        end else begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q == ST_SAVE) || (state_q == ST_RESTORE);
    done          = (state_q == ST_FINISH);
    rd_reg        = '0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    mem.mem_we    = 1'b0;
    mem.mem_re    = 1'b0;
    wr_reg        = '0;
    wr_data       = '0;
    wr_en         = 1'b0;
    if (state_q == ST_SAVE) begin
      rd_reg        = idx_q;
      mem.mem_addr  = slot_addr;
      mem.mem_wdata = rd_data;
      mem.mem_we    = 1'b1;
    end
    if (issue) begin
      mem.mem_addr = slot_addr;
      mem.mem_re   = 1'b1;
    end
    if (pend_q) begin
      wr_reg  = pend_idx_q;
      wr_data = mem.mem_rdata;
      wr_en   = 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_spill_ctrl.sv
// Directed bench for reg_spill_ctrl: register file and 1-cycle memory models around the DUT.
module tb_reg_spill_ctrl;
  import reg_spill_ctrl_pkg::*;

  logic  clk = 1'b0;
  logic  reset;
  logic  start_save;
  logic  start_restore;
  addr_t base_addr;
  mask_t reg_mask;
  logic  busy;
  logic  done;
  idx_t  rd_reg;
  data_t rd_data;
  idx_t  wr_reg;
  data_t wr_data;
  logic  wr_en;

  reg_spill_ctrl_if mem_if ();

  reg_spill_ctrl #(.MEM_LAT(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .start_save    (start_save),
    .start_restore (start_restore),
    .base_addr     (base_addr),
    .reg_mask      (reg_mask),
    .busy          (busy),
    .done          (done),
    .rd_reg        (rd_reg),
    .rd_data       (rd_data),
    .wr_reg        (wr_reg),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .mem           (mem_if)
  );

  always #5 clk = ~clk;

  data_t regs    [NUM_REGS];
  data_t mem_arr [1024];
  data_t rdata_q;
  logic  pre_reg_we;
  logic  pre_mem_we;
  addr_t pre_addr;
  data_t pre_data;

  always @(posedge clk) begin
    if (pre_reg_we)  regs[pre_addr[IDX_W-1:0]] <= pre_data;
    else if (wr_en)  regs[wr_reg] <= wr_data;
    if (pre_mem_we)          mem_arr[pre_addr] <= pre_data;
    else if (mem_if.mem_we)  mem_arr[mem_if.mem_addr] <= mem_if.mem_wdata;
    if (mem_if.mem_re) rdata_q <= mem_arr[mem_if.mem_addr];
  end

  assign rd_data          = regs[rd_reg];
  assign mem_if.mem_rdata = rdata_q;

  int checks = 0;
  int errors = 0;
  int busy_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_reg(input int i, input data_t v);
    pre_reg_we = 1'b1;
    pre_addr   = addr_t'(i);
    pre_data   = v;
    tick();
    pre_reg_we = 1'b0;
  endtask

  task automatic load_mem(input addr_t a, input data_t v);
    pre_mem_we = 1'b1;
    pre_addr   = a;
    pre_data   = v;
    tick();
    pre_mem_we = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_we"},    mem_if.mem_we, 0);
    check({tag, "_re"},    mem_if.mem_re, 0);
    check({tag, "_wr_en"}, wr_en, 0);
  endtask

  initial begin
    reset = 1'b1; start_save = 1'b0; start_restore = 1'b0;
    base_addr = '0; reg_mask = '0;
    pre_reg_we = 1'b0; pre_mem_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (3) tick();

    // Reset state
    check_quiet("rst");
    check("rst_rd_reg", rd_reg, 0);
    check("rst_wr_reg", wr_reg, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_addr", mem_if.mem_addr, 0);
    check("rst_wdata", mem_if.mem_wdata, 0);

    for (int i = 0; i < NUM_REGS; i++) load_reg(i, data_t'(i + 1));
    reset = 1'b0;
    tick();

    // Scenario 1: full save of regs 0x001..0x008 to 0x100..0x107
    base_addr = 10'h100; reg_mask = 8'hFF; start_save = 1'b1;
    tick();
    start_save = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("s1_we", mem_if.mem_we, 1);
      check("s1_addr", mem_if.mem_addr, 32'h100 + i);
      check("s1_wdata", mem_if.mem_wdata, i + 1);
      check("s1_rd_reg", rd_reg, i);
      check("s1_busy", busy, 1);
      check("s1_wr_en", wr_en, 0);
      check("s1_done", done, 0);
      tick();
    end
    check("s1_fin_done", done, 1);
    check("s1_fin_busy", busy, 0);
    check("s1_fin_we", mem_if.mem_we, 0);
    tick();
    check_quiet("s1_idle");

    // Scenario 2: full restore from 0x200..0x207 holding 0x3FF downward
    for (int i = 0; i < 8; i++) load_mem(addr_t'(10'h200 + i), data_t'(10'h3FF - i));
    base_addr = 10'h200; reg_mask = 8'hFF; start_restore = 1'b1;
    tick();
    start_restore = 1'b0;
    busy_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      if (busy) busy_cnt++;
      if (c <= 8) begin
        check("s2_re", mem_if.mem_re, 1);
        check("s2_addr", mem_if.mem_addr, 32'h200 + c - 1);
      end else begin
        check("s2_re_off", mem_if.mem_re, 0);
      end
      if (c >= 2 && c <= 9) begin
        check("s2_wr_en", wr_en, 1);
        check("s2_wr_reg", wr_reg, c - 2);
        check("s2_wr_data", wr_data, 32'h3FF - (c - 2));
      end else begin
        check("s2_wr_en_off", wr_en, 0);
      end
      check("s2_we", mem_if.mem_we, 0);
      check("s2_done", done, (c == 10) ? 1 : 0);
      tick();
    end
    check("s2_busy_cycles", busy_cnt, 9);
    check_quiet("s2_idle");

    // Scenario 3: sparse mask 0x81, base 0x3FF wraps reg7 to 0x006
    base_addr = 10'h3FF; reg_mask = 8'h81; start_save = 1'b1;
    tick();
    start_save = 1'b0;
    check("s3_c1_we", mem_if.mem_we, 1);
    check("s3_c1_rd_reg", rd_reg, 0);
    check("s3_c1_addr", mem_if.mem_addr, 32'h3FF);
    check("s3_c1_wdata", mem_if.mem_wdata, 32'h3FF);
    tick();
    check("s3_c2_we", mem_if.mem_we, 1);
    check("s3_c2_rd_reg", rd_reg, 7);
    check("s3_c2_addr", mem_if.mem_addr, 32'h006);
    check("s3_c2_wdata", mem_if.mem_wdata, 32'h3F8);
    tick();
    check("s3_done", done, 1);
    check("s3_we_off", mem_if.mem_we, 0);
    tick();

    // Scenario 4: simultaneous starts pick save; mid-save restore ignored
    base_addr = 10'h040; reg_mask = 8'h03; start_save = 1'b1; start_restore = 1'b1;
    tick();
    start_save = 1'b0; start_restore = 1'b0;
    check("s4_c1_we", mem_if.mem_we, 1);
    check("s4_c1_re", mem_if.mem_re, 0);
    check("s4_c1_addr", mem_if.mem_addr, 32'h040);
    start_restore = 1'b1;
    tick();
    start_restore = 1'b0;
    check("s4_c2_we", mem_if.mem_we, 1);
    check("s4_c2_addr", mem_if.mem_addr, 32'h041);
    check("s4_c2_busy", busy, 1);
    tick();
    check("s4_done", done, 1);
    tick();
    check_quiet("s4_idle");
    tick();
    check_quiet("s4_idle2");

    // Empty mask: done on the cycle after start, for both directions
    reg_mask = 8'h00; start_save = 1'b1;
    tick();
    start_save = 1'b0;
    check("s4_m0s_done", done, 1);
    check("s4_m0s_busy", busy, 0);
    check("s4_m0s_we", mem_if.mem_we, 0);
    tick();
    check("s4_m0s_done_off", done, 0);
    start_restore = 1'b1;
    tick();
    start_restore = 1'b0;
    check("s4_m0r_done", done, 1);
    check("s4_m0r_re", mem_if.mem_re, 0);
    tick();
    check_quiet("s4_m0r_idle");

    // Start together with reset is ignored
    reset = 1'b1; reg_mask = 8'hFF; start_save = 1'b1;
    tick();
    reset = 1'b0; start_save = 1'b0;
    check_quiet("rst_start");
    tick();
    check_quiet("rst_start2");

    // Scenario 5: reset during the 4th restore cycle
    for (int i = 0; i < 8; i++) load_mem(addr_t'(10'h300 + i), data_t'(10'h0A0 + i));
    base_addr = 10'h300; reg_mask = 8'hFF; start_restore = 1'b1;
    tick();
    start_restore = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check("s5_re", mem_if.mem_re, 1);
      tick();
    end
    check("s5_c4_addr", mem_if.mem_addr, 32'h303);
    check("s5_c4_wr_en", wr_en, 1);
    check("s5_c4_wr_reg", wr_reg, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_quiet("s5_abort");
    check("s5_wr_reg", wr_reg, 0);
    check("s5_wr_data", wr_data, 0);
    check("s5_addr", mem_if.mem_addr, 0);
    tick();
    check_quiet("s5_after1");
    tick();
    check("s5_no_done", done, 0);
    check("s5_reg2", regs[2], 32'h0A2);
    for (int i = 3; i < 8; i++) check("s5_reg_kept", regs[i], 32'h3FF - i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_spill_ctrl.md
REG_SPILL_CTRL -- requirements
Module: reg_spill_ctrl

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning data-memory read latency in cycles; only the value 1 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start_save, input, 1, one-cycle request to copy the register file to memory.
REQ-005 SHALL have port start_restore, input, 1, one-cycle request to copy memory into the register file.
REQ-006 SHALL have port base_addr, input, 10, memory base address of the 8-slot save area.
REQ-007 SHALL have port reg_mask, input, 8, bit i set means register i takes part in the operation.
REQ-008 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port rd_reg, output, 3, register-file read address.
REQ-011 SHALL have port rd_data, input, 10, combinational register-file read data for rd_reg.
REQ-012 SHALL have ports wr_reg (output, 3), wr_data (output, 10) and wr_en (output, 1), the register-file write port.
REQ-013 SHALL have ports mem_addr (output, 10), mem_wdata (output, 10), mem_we (output, 1), mem_re (output, 1) and mem_rdata (input, 10); mem_rdata is valid one cycle after mem_re.

Function
REQ-014 SHALL implement states IDLE, SAVE, RESTORE and FINISH.
REQ-015 In IDLE, start_save SHALL capture base_addr and reg_mask and go to SAVE; start_restore SHALL capture them and go to RESTORE.
REQ-016 If start_save and start_restore are both high in IDLE, save SHALL win.
REQ-017 Start requests outside IDLE SHALL be ignored.
REQ-018 The index walks upward from 0 to 7 and visits only registers whose captured mask bit is set; unmasked indices SHALL consume no cycles.
REQ-019 Each SAVE cycle for index i SHALL drive rd_reg=i, mem_addr=base+i, mem_wdata=rd_data and mem_we=1.
REQ-020 Each RESTORE issue cycle for index i SHALL drive mem_addr=base+i and mem_re=1.
REQ-021 For a restore read issued in cycle k, the block SHALL drive wr_reg=i, wr_data=mem_rdata and wr_en=1 in cycle k+1, overlapping with the next issue.
REQ-022 Address arithmetic SHALL be base+i modulo 1024, so a save area starting at 1020 wraps to 0.
REQ-023 FINISH SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-024 Cycle counts for N set mask bits: save is N cycles in SAVE; restore is N issue cycles plus one trailing write cycle, then FINISH.
REQ-025 With a mask of 0, the block SHALL go straight to FINISH on the cycle after start.
REQ-026 busy SHALL be 1 in SAVE and RESTORE, including the trailing write cycle.
REQ-027 mem_we, mem_re and wr_en SHALL be 0 outside their active cycles.
REQ-028 mem_we and wr_en SHALL never both be 1 in the same cycle.

Reset
REQ-029 Reset SHALL force IDLE with busy, done, wr_en, mem_we and mem_re at 0, and rd_reg, wr_reg, wr_data, mem_addr and mem_wdata at 0.
REQ-030 Reset during an operation SHALL abort it: no further writes, no done pulse, and a pending restore write is dropped.
REQ-031 start_save and start_restore asserted in the same cycle as reset SHALL be ignored.

Structure
REQ-032 State encodings and the constants NUM_REGS=8 and DATA_W=10 SHALL live in a shared package used with the register file.
REQ-033 The next-set-bit search SHALL be one sub-module, next_idx_find: inputs mask[7:0] and from[2:0], outputs idx[2:0] and none.

Verification
REQ-034 Scenario 1 (full save): registers hold 10'h001..10'h008, base=0x100, mask=0xFF, start_save -> 8 consecutive mem_we cycles to 0x100..0x107 with data 0x001..0x008, then done one cycle later.
REQ-035 Scenario 2 (full restore): memory 0x200..0x207 holds 0x3FF down to 0x3F8, mask=0xFF -> wr_en on regs 0..7 in cycles 2..9 with those values, then done; total busy is 9 cycles.
REQ-036 Scenario 3 (sparse mask, wrap): mask=0x81, base=0x3FF -> save writes reg0 to 0x3FF and reg7 to 0x006 in 2 cycles.
REQ-037 Scenario 4 (contention): start_save and start_restore together -> save performed; start_restore pulsed mid-save is ignored; mask=0 -> done on the cycle after start.
REQ-038 Scenario 5 (reset abort): reset during the 4th restore cycle -> wr_en low from the next cycle, no done, IDLE, and regs 3..7 unchanged.
